bcd_countdown_timer: RTL and testbench

//   Multi-digit BCD countdown timer (default MM:SS) for the microwave controller timer path.
//   - Cascades NUM_DIGITS per-digit-modulus BCD down-counters behind a run/pause/done FSM.
//   - Counts down on a 1 Hz `tick` strobe, stops at zero, and pulses `done` for the cook-end logic.

---
 rtl/bcd_countdown_timer_pkg.sv | 25 ++
 rtl/bcd_digit_down.sv | 41 ++++
 rtl/bcd_countdown_timer.sv | 128 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   DIGIT_W      : bits per BCD digit
//   state_e      : FSM encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   digit_mod()  : extracts the modulus of digit i from a packed DIGIT_MODS word
//   clamp_digit(): forces a digit that is out of range to MOD-1
package bcd_countdown_timer_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [3:0] digit_mod(input logic [31:0] mods, input int i);
    return mods[i*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mod);
    return (d >= mod) ? (mod - 4'd1) : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD down-counter digit with a programmable modulus.
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset (q -> 0)
//   load : load clamp(d); wins over en
//   en   : decrement enable (borrow-in)
//   d    : load value
//   q    : current digit
//   tc   : borrow-out, combinational (en and q == 0)
module bcd_digit_down
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tc
);

  logic [3:0] q_q, q_d;

  assign q  = q_q;
  assign tc = en & (q_q == 4'd0);

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = clamp_digit(d, MOD);
    else if (en)
      q_d = (q_q == 4'd0) ? (MOD - 4'd1) : (q_q - 4'd1);
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= 4'd0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer (default MM:SS) with run/pause/done FSM.
//   clk, clr        : clock, synchronous active-high reset
//   load, data      : load clamped BCD value into counter and preset register
//   start, stop     : request RUN / PAUSE (stop wins when both are set)
//   tick            : one-clk count-enable strobe, honoured only in RUN
//   out             : current BCD count
//   tc              : per-digit borrow-out (combinational)
//   zero            : out == 0 (combinational)
//   done            : registered one-cycle pulse on the terminal tick
//   running         : registered, state == RUN
// Optional feature: define BCD_TIMER_AUTORELOAD_EN to reload the preset on the
// terminal tick and keep running (a zero preset still ends in DONE).
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter logic [31:0] DIGIT_MODS = 32'h0000_6A6A
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0]   data,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            tick,
  output logic [DIGIT_W*NUM_DIGITS-1:0]   out,
  output logic [NUM_DIGITS-1:0]           tc,
  output logic                            zero,
  output logic                            done,
  output logic                            running
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  state_e         state_q, state_d;
  logic           done_q, done_d;
  logic           running_q, running_d;
  logic [W-1:0]   preset_q, preset_d;

  logic [NUM_DIGITS-1:0] en;
  logic                  tick_run, terminal, reload, dig_load;
  logic [W-1:0]          dig_d;

  // load and stop both outrank tick, so they block the decrement.
  assign tick_run = tick & (state_q == ST_RUN) & ~load & ~stop;
  // Only digit 0 == 1 with all higher digits 0 decrements to all-zero.
  assign terminal = tick_run & (out == W'(1));

`ifdef BCD_TIMER_AUTORELOAD_EN
  assign reload = terminal & (preset_q != '0);
`else
  assign reload = 1'b0;
`endif

  // Reload reuses the digits' load path; an external load always wins.
  assign dig_load = load | reload;
  assign dig_d    = load ? data : preset_q;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      if (g == 0) begin : g_first
        assign en[g] = tick_run;
      end else begin : g_rest
        assign en[g] = tc[g-1];
      end
      bcd_digit_down #(
        .MOD(digit_mod(DIGIT_MODS, g))
      ) u_dig (
        .clk  (clk),
        .clr  (clr),
        .load (dig_load),
        .en   (en[g]),
        .d    (dig_d[g*DIGIT_W +: DIGIT_W]),
        .q    (out[g*DIGIT_W +: DIGIT_W]),
        .tc   (tc[g])
      );
    end
  endgenerate

  assign zero    = (out == '0);
  assign done    = done_q;
  assign running = running_q;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    preset_d = preset_q;
    if (load) begin
      state_d = ST_IDLE;
      for (int i = 0; i < NUM_DIGITS; i++)
        preset_d[i*DIGIT_W +: DIGIT_W] =
          clamp_digit(data[i*DIGIT_W +: DIGIT_W], digit_mod(DIGIT_MODS, i));
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          // Starting from zero would finish instantly; ignore it instead.
          if (!stop && start && !zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (terminal) begin
            done_d  = 1'b1;
            state_d = reload ? ST_RUN : ST_DONE;
          end
        end
        default: ;  // DONE: only load or clr leave
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      preset_q  <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      running_q <= running_d;
      preset_q  <= preset_d;
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (default 4-digit MM:SS build).
// The driver applies inputs at the falling edge and queues expectations tagged
// with the time they become observable; the monitor samples 2 ns after each
// falling edge and retires every expectation due at that time.
module tb_bcd_countdown_timer;

  typedef enum int {K_OUT, K_TC, K_ZERO, K_DONE, K_RUN} kind_e;
  typedef struct {
    time         due;
    kind_e       kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr, load, start, stop, tick;
  logic [15:0] data;
  logic [15:0] out;
  logic [3:0]  tc;
  logic        zero, done, running;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bcd_countdown_timer dut (
    .clk(clk), .clr(clr), .load(load), .data(data), .start(start),
    .stop(stop), .tick(tick), .out(out), .tc(tc), .zero(zero),
    .done(done), .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mmss(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic drive(input bit c, input bit ld, input logic [15:0] dat,
                       input bit st, input bit sp, input bit tk);
    @(negedge clk);
    clr = c; load = ld; data = dat; start = st; stop = sp; tick = tk;
  endtask

  // post=1: value seen after the coming rising edge; post=0: seen now (comb).
  task automatic expect_v(input kind_e k, input logic [15:0] v, input string n, input bit post);
    exp_t e;
    e.due = $time + (post ? 12 : 2);
    e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic expect_state(input logic [15:0] o, input bit d, input bit r, input string n);
    expect_v(K_OUT, o, {n, ".out"}, 1'b1);
    expect_v(K_DONE, 16'(d), {n, ".done"}, 1'b1);
    expect_v(K_RUN, 16'(r), {n, ".running"}, 1'b1);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= $time) begin
          logic [15:0] got;
          case (sb[i].kind)
            K_OUT:   got = out;
            K_TC:    got = 16'(tc);
            K_ZERO:  got = 16'(zero);
            K_DONE:  got = 16'(done);
            default: got = 16'(running);
          endcase
          checks++;
          if (sb[i].due < $time) begin
            errors++;
            $display("FAIL %s: expectation missed its sample time", sb[i].name);
          end else if (got !== sb[i].val) begin
            errors++;
            $display("FAIL %s: got %h want %h", sb[i].name, got, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  // Driver
  initial begin
    clr = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; data = '0;

    // Reset state
    drive(1, 0, 16'h0, 0, 0, 0);
    expect_state(16'h0000, 0, 0, "reset");
    expect_v(K_ZERO, 16'd1, "reset.zero", 1'b1);
    expect_v(K_TC, 16'h0, "reset.tc", 1'b1);

    // 1: 1:30 countdown to zero
    drive(0, 1, 16'h0130, 0, 0, 0);
    expect_state(16'h0130, 0, 0, "t1.load");
    drive(0, 0, 16'h0, 1, 0, 0);
    expect_state(16'h0130, 0, 1, "t1.start");
    for (int i = 1; i <= 90; i++) begin
      drive(0, 0, 16'h0, 0, 0, 1);
      expect_state(mmss(90 - i), i == 90, i != 90, $sformatf("t1.tick%0d", i));
    end
    drive(0, 0, 16'h0, 0, 0, 0);
    expect_state(16'h0000, 0, 0, "t1.done_one_cycle");
    expect_v(K_ZERO, 16'd1, "t1.zero", 1'b1);
    drive(0, 0, 16'h0, 0, 0, 1);
    expect_state(16'h0000, 0, 0, "t1.tick_in_done");
    drive(0, 0, 16'h0, 1, 0, 0);
    expect_state(16'h0000, 0, 0, "t1.start_in_done");

    // 2: borrow chain 10:00 -> 09:59
    drive(0, 1, 16'h1000, 0, 0, 0);
    drive(0, 0, 16'h0, 1, 0, 0);
    drive(0, 0, 16'h0, 0, 0, 1);
    expect_v(K_TC, 16'h7, "t2.tc", 1'b0);
    expect_state(16'h0959, 0, 1, "t2.tick");

    // 3: clamp on load
    drive(0, 1, 16'h9F9C, 0, 0, 0);
    expect_state(16'h5959, 0, 0, "t3.clamp");

    // 4: pause / resume
    drive(0, 1, 16'h0010, 0, 0, 0);
    drive(0, 0, 16'h0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) drive(0, 0, 16'h0, 0, 0, 1);
    expect_state(16'h0007, 0, 1, "t4.run3");
    drive(0, 0, 16'h0, 0, 1, 0);
    expect_state(16'h0007, 0, 0, "t4.stop");
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 16'h0, 0, 0, 1);
      expect_state(16'h0007, 0, 0, $sformatf("t4.paused%0d", i));
    end
    drive(0, 0, 16'h0, 1, 0, 0);
    expect_state(16'h0007, 0, 1, "t4.resume");
    for (int i = 1; i <= 7; i++) begin
      drive(0, 0, 16'h0, 0, 0, 1);
      expect_state(16'(7 - i), i == 7, i != 7, $sformatf("t4.tick%0d", i));
    end

    // 5: corner cases
    drive(1, 0, 16'h0, 0, 0, 0);
    drive(0, 0, 16'h0, 1, 0, 0);
    expect_state(16'h0000, 0, 0, "t5.start_at_zero");
    drive(0, 1, 16'h0005, 0, 0, 0);
    drive(0, 0, 16'h0, 0, 0, 1);
    expect_state(16'h0005, 0, 0, "t5.tick_idle");
    drive(0, 0, 16'h0, 1, 1, 0);
    expect_state(16'h0005, 0, 0, "t5.start_stop");
    drive(0, 0, 16'h0, 1, 0, 0);
    expect_state(16'h0005, 0, 1, "t5.start");
    drive(0, 0, 16'h0, 0, 0, 1);
    expect_state(16'h0004, 0, 1, "t5.tick");
    drive(1, 0, 16'h0, 0, 0, 1);
    expect_state(16'h0000, 0, 0, "t5.clr_mid_run");
    drive(0, 0, 16'h0, 0, 0, 0);
    expect_state(16'h0000, 0, 0, "t5.no_done");

    // 6: terminal tick behaviour (auto-reload optional)
    drive(0, 1, 16'h0003, 0, 0, 0);
    drive(0, 0, 16'h0, 1, 0, 0);
    drive(0, 0, 16'h0, 0, 0, 1);
    drive(0, 0, 16'h0, 0, 0, 1);
    drive(0, 0, 16'h0, 0, 0, 1);
`ifdef BCD_TIMER_AUTORELOAD_EN
    expect_state(16'h0003, 1, 1, "t6.reload1");
    drive(0, 0, 16'h0, 0, 0, 1);
    drive(0, 0, 16'h0, 0, 0, 1);
    drive(0, 0, 16'h0, 0, 0, 1);
    expect_state(16'h0003, 1, 1, "t6.reload2");
`else
    expect_state(16'h0000, 1, 0, "t6.terminal");
`endif
    drive(0, 0, 16'h0, 0, 0, 0);
    expect_v(K_DONE, 16'd0, "t6.done_drop", 1'b1);

    drive(0, 0, 16'h0, 0, 0, 0);
    drive(0, 0, 16'h0, 0, 0, 0);
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
